// File: rtl/bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter
//  Shares one read-only image BRAM port (RD_LAT-cycle read latency) between
//  two burst requesters: the VGA pixel stream (req 0) and the preprocess
//  window fetch (req 1). One burst is granted at a time. Returned data is
//  steered to the owner only, together with a valid strobe and a done pulse.
//
//  Optional feature: define BRAM_ARB_RR_EN for round-robin arbitration.
//  Without the macro, arbitration is fixed priority and VGA wins.
//
//  Ports
//   clk, rst            clock, synchronous active-high reset
//   ena_o/wea_o/addr_o  BRAM control (wea_o tied low)
//   mem2d_i             BRAM read data
//   vga_* / pre_*       per-requester request (req/addr/len), grant pulse,
//                       read data, data valid and done pulse
//   busy_o              arbiter is not idle
//   owner_o             current or last burst owner (0=VGA, 1=PRE)
// ---------------------------------------------------------------------------
module bram_read_arbiter #(
   parameter int unsigned ADDR_W   = 18,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned LEN_W    = 20,
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned MAX_ADDR = 194400
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ena_o,
   output logic              wea_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic [DATA_W-1:0] mem2d_i,
   input  logic              vga_req_i,
   input  logic [ADDR_W-1:0] vga_addr_i,
   input  logic [LEN_W-1:0]  vga_len_i,
   output logic              vga_gnt_o,
   output logic [DATA_W-1:0] vga_data_o,
   output logic              vga_data_en_o,
   output logic              vga_done_o,
   input  logic              pre_req_i,
   input  logic [ADDR_W-1:0] pre_addr_i,
   input  logic [LEN_W-1:0]  pre_len_i,
   output logic              pre_gnt_o,
   output logic [DATA_W-1:0] pre_data_o,
   output logic              pre_data_en_o,
   output logic              pre_done_o,
   output logic              busy_o,
   output logic              owner_o
);

   localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [DRN_W-1:0]    drn_q, drn_d;
   logic                ena_q, ena_d;
   logic                busy_q, busy_d;
   logic                vga_gnt_q, vga_gnt_d;
   logic                pre_gnt_q, pre_gnt_d;
   logic                vga_zdone_q, vga_zdone_d;
   logic                pre_zdone_q, pre_zdone_d;
`ifdef BRAM_ARB_RR_EN
   logic                pref_q, pref_d;
`endif

   // read-return tracking: valid, owner and last-word flag per issued read
   logic [RD_LAT-1:0]   vld_pipe_q;
   logic [RD_LAT-1:0]   own_pipe_q;
   logic [RD_LAT-1:0]   lst_pipe_q;

   logic                any_req;
   logic                win_pre;
   logic [ADDR_W-1:0]   sel_addr;
   logic [LEN_W-1:0]    sel_len;
   logic [ADDR_W-1:0]   sel_base;
   logic                ret_vld, ret_own, ret_lst;

   // winner selection (only acted on in IDLE)
   always_comb begin
      any_req = vga_req_i | pre_req_i;
`ifdef BRAM_ARB_RR_EN
      // pref_q holds the requester that wins the next contention
      win_pre = pre_req_i & (~vga_req_i | pref_q);
`else
      win_pre = pre_req_i & ~vga_req_i;
`endif
      sel_addr = win_pre ? pre_addr_i : vga_addr_i;
      sel_len  = win_pre ? pre_len_i  : vga_len_i;
      sel_base = (sel_addr >= ADDR_W'(MAX_ADDR)) ? '0 : sel_addr;
   end

   // next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      drn_d       = drn_q;
      ena_d       = 1'b0;
      vga_gnt_d   = 1'b0;
      pre_gnt_d   = 1'b0;
      vga_zdone_d = 1'b0;
      pre_zdone_d = 1'b0;
`ifdef BRAM_ARB_RR_EN
      pref_d      = pref_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d   = win_pre;
               vga_gnt_d = ~win_pre;
               pre_gnt_d = win_pre;
`ifdef BRAM_ARB_RR_EN
               pref_d    = ~win_pre;
`endif
               if (sel_len == '0) begin
                  // empty burst: done rides with the grant, no reads
                  vga_zdone_d = ~win_pre;
                  pre_zdone_d = win_pre;
               end else begin
                  state_d = ST_BURST;
                  ena_d   = 1'b1;
                  addr_d  = sel_base;
                  cnt_d   = sel_len;
               end
            end
         end
         ST_BURST: begin
            if (cnt_q == LEN_W'(1)) begin
               state_d = ST_DRAIN;
               drn_d   = DRN_W'(RD_LAT - 1);
            end else begin
               ena_d  = 1'b1;
               cnt_d  = cnt_q - LEN_W'(1);
               addr_d = (addr_q == ADDR_W'(MAX_ADDR - 1)) ? '0 : addr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (drn_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               drn_d = drn_q - DRN_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
         drn_q       <= '0;
         ena_q       <= 1'b0;
         busy_q      <= 1'b0;
         vga_gnt_q   <= 1'b0;
         pre_gnt_q   <= 1'b0;
         vga_zdone_q <= 1'b0;
         pre_zdone_q <= 1'b0;
`ifdef BRAM_ARB_RR_EN
         pref_q      <= 1'b0;
`endif
         vld_pipe_q  <= '0;
         own_pipe_q  <= '0;
         lst_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         drn_q       <= drn_d;
         ena_q       <= ena_d;
         busy_q      <= busy_d;
         vga_gnt_q   <= vga_gnt_d;
         pre_gnt_q   <= pre_gnt_d;
         vga_zdone_q <= vga_zdone_d;
         pre_zdone_q <= pre_zdone_d;
`ifdef BRAM_ARB_RR_EN
         pref_q      <= pref_d;
`endif
         // ena_q is high exactly in BURST, so cnt_q==1 marks the last issue
         vld_pipe_q[0] <= ena_q;
         own_pipe_q[0] <= owner_q;
         lst_pipe_q[0] <= ena_q & (cnt_q == LEN_W'(1));
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            own_pipe_q[i] <= own_pipe_q[i-1];
            lst_pipe_q[i] <= lst_pipe_q[i-1];
         end
      end
   end

   assign ret_vld = vld_pipe_q[RD_LAT-1];
   assign ret_own = own_pipe_q[RD_LAT-1];
   assign ret_lst = lst_pipe_q[RD_LAT-1];

   assign ena_o   = ena_q;
   assign wea_o   = 1'b0;
   assign addr_o  = addr_q;
   assign busy_o  = busy_q;
   assign owner_o = owner_q;

   assign vga_gnt_o = vga_gnt_q;
   assign pre_gnt_o = pre_gnt_q;

   // mem2d_i is valid in the return cycle itself, so data is steered, not re-registered
   assign vga_data_en_o = ret_vld & ~ret_own;
   assign pre_data_en_o = ret_vld & ret_own;
   assign vga_data_o    = vga_data_en_o ? mem2d_i : '0;
   assign pre_data_o    = pre_data_en_o ? mem2d_i : '0;
   assign vga_done_o    = (vga_data_en_o & ret_lst) | vga_zdone_q;
   assign pre_done_o    = (pre_data_en_o & ret_lst) | pre_zdone_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_read_arbiter
//  Self-checking bench for bram_read_arbiter. A behavioural BRAM returns
//  mem_val(addr) RD_LAT cycles after an enabled read. Expected addresses and
//  per-requester data words are queued when a request is driven and popped
//  by a monitor as the DUT issues reads and returns data.
// ---------------------------------------------------------------------------
module tb_bram_read_arbiter;

   localparam int unsigned ADDR_W   = 18;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned LEN_W    = 20;
   localparam int unsigned RD_LAT   = 2;
   localparam int unsigned MAX_ADDR = 194400;

   logic              clk = 1'b0;
   logic              rst;
   logic              ena_o, wea_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] mem2d_i;
   logic              vga_req_i, pre_req_i;
   logic [ADDR_W-1:0] vga_addr_i, pre_addr_i;
   logic [LEN_W-1:0]  vga_len_i, pre_len_i;
   logic              vga_gnt_o, vga_data_en_o, vga_done_o;
   logic              pre_gnt_o, pre_data_en_o, pre_done_o;
   logic [DATA_W-1:0] vga_data_o, pre_data_o;
   logic              busy_o, owner_o;

   bram_read_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
      .RD_LAT(RD_LAT), .MAX_ADDR(MAX_ADDR)
   ) dut (
      .clk(clk), .rst(rst),
      .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o), .mem2d_i(mem2d_i),
      .vga_req_i(vga_req_i), .vga_addr_i(vga_addr_i), .vga_len_i(vga_len_i),
      .vga_gnt_o(vga_gnt_o), .vga_data_o(vga_data_o),
      .vga_data_en_o(vga_data_en_o), .vga_done_o(vga_done_o),
      .pre_req_i(pre_req_i), .pre_addr_i(pre_addr_i), .pre_len_i(pre_len_i),
      .pre_gnt_o(pre_gnt_o), .pre_data_o(pre_data_o),
      .pre_data_en_o(pre_data_en_o), .pre_done_o(pre_done_o),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
      return DATA_W'(a ^ (a >> 7)) ^ 8'h5A;
   endfunction

   // behavioural BRAM; non-read cycles return filler so leaks are visible
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= ena_o ? mem_val(addr_o) : 8'hEE;
      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem2d_i = rd_pipe[RD_LAT-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              last;
   } exp_t;

   logic [ADDR_W-1:0] addr_exp [$];
   exp_t              vga_exp [$];
   exp_t              pre_exp [$];
   int                vga_zpend = 0;
   int                pre_zpend = 0;
   int                pre_gnt_cnt = 0;
   bit                mon_en = 1'b0;

   // scoreboard monitor, sampled mid-cycle
   always @(negedge clk) begin
      logic [ADDR_W-1:0] a;
      exp_t              e;
      if (mon_en && !rst) begin
         check("wea", 32'(wea_o), 0);
         if (ena_o) begin
            if (addr_exp.size() == 0) check("ena_unexpected", 32'(ena_o), 0);
            else begin
               a = addr_exp.pop_front();
               check("addr", 32'(addr_o), 32'(a));
            end
         end
         if (vga_data_en_o) begin
            if (vga_exp.size() == 0) check("vga_data_en_unexpected", 32'(vga_data_en_o), 0);
            else begin
               e = vga_exp.pop_front();
               check("vga_data", 32'(vga_data_o), 32'(e.d));
               check("vga_done_last", 32'(vga_done_o), 32'(e.last));
            end
         end else begin
            check("vga_data_idle_zero", 32'(vga_data_o), 0);
            if (vga_done_o && vga_zpend > 0) vga_zpend--;
            else check("vga_done_idle", 32'(vga_done_o), 0);
         end
         if (pre_data_en_o) begin
            if (pre_exp.size() == 0) check("pre_data_en_unexpected", 32'(pre_data_en_o), 0);
            else begin
               e = pre_exp.pop_front();
               check("pre_data", 32'(pre_data_o), 32'(e.d));
               check("pre_done_last", 32'(pre_done_o), 32'(e.last));
            end
         end else begin
            check("pre_data_idle_zero", 32'(pre_data_o), 0);
            if (pre_done_o && pre_zpend > 0) pre_zpend--;
            else check("pre_done_idle", 32'(pre_done_o), 0);
         end
         if (pre_gnt_o) pre_gnt_cnt++;
      end
   end

   task automatic push_burst(input bit who, input logic [ADDR_W-1:0] base, input int len);
      logic [ADDR_W-1:0] a;
      exp_t              e;
      a = (base >= ADDR_W'(MAX_ADDR)) ? '0 : base;
      for (int i = 0; i < len; i++) begin
         addr_exp.push_back(a);
         e.d    = mem_val(a);
         e.last = (i == len - 1);
         if (who) pre_exp.push_back(e);
         else     vga_exp.push_back(e);
         a = (a == ADDR_W'(MAX_ADDR - 1)) ? '0 : a + ADDR_W'(1);
      end
   endtask

   task automatic drive_req(input bit who, input bit on, input logic [ADDR_W-1:0] base,
                            input logic [LEN_W-1:0] len);
      if (who) begin
         pre_req_i = on; pre_addr_i = base; pre_len_i = len;
      end else begin
         vga_req_i = on; vga_addr_i = base; vga_len_i = len;
      end
   endtask

   task automatic wait_gnt(input bit who, output int lat);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (who ? pre_gnt_o : vga_gnt_o) begin
            lat = i;
            break;
         end
      end
      check("gnt_seen", 32'(lat > 0), 1);
   endtask

   task automatic wait_not_busy();
      for (int i = 0; i < 100; i++) begin
         if (!busy_o) break;
         @(negedge clk);
      end
      check("busy_clears", 32'(busy_o), 0);
   endtask

   // single uncontended burst, checked end to end
   task automatic run_burst(input bit who, input logic [ADDR_W-1:0] base, input int len);
      int lat;
      if (len > 0) push_burst(who, base, len);
      else if (who) pre_zpend++;
      else vga_zpend++;
      drive_req(who, 1'b1, base, LEN_W'(len));
      wait_gnt(who, lat);
      drive_req(who, 1'b0, base, LEN_W'(len));
      check("owner_after_gnt", 32'(owner_o), 32'(who));
      if (len == 0) begin
         check("zlen_done_with_gnt", 32'(who ? pre_done_o : vga_done_o), 1);
         check("zlen_busy", 32'(busy_o), 0);
         check("zlen_ena", 32'(ena_o), 0);
         @(negedge clk);
         check("zlen_busy_after", 32'(busy_o), 0);
      end
      wait_not_busy();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      addr_exp.delete(); vga_exp.delete(); pre_exp.delete();
      vga_zpend = 0; pre_zpend = 0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int lat, vga_first, vga_second, pre_at, gcnt;
      int exp_vga2, exp_pre;
      rst = 1'b1;
      drive_req(1'b0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check("rst_ena", 32'(ena_o), 0);
      check("rst_addr", 32'(addr_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_owner", 32'(owner_o), 0);
      check("rst_vga_gnt", 32'(vga_gnt_o), 0);
      check("rst_pre_gnt", 32'(pre_gnt_o), 0);
      check("rst_vga_en", 32'(vga_data_en_o), 0);
      check("rst_pre_done", 32'(pre_done_o), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // VGA base 0 len 4, cycle-exact
      push_burst(1'b0, '0, 4);
      drive_req(1'b0, 1'b1, '0, LEN_W'(4));
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("t1_vga_gnt", 32'(vga_gnt_o), 32'(k == 1));
         check("t1_ena", 32'(ena_o), 32'(k >= 1 && k <= 4));
         check("t1_vga_en", 32'(vga_data_en_o), 32'(k >= 3 && k <= 6));
         check("t1_vga_done", 32'(vga_done_o), 32'(k == 6));
         check("t1_busy", 32'(busy_o), 32'(k <= 6));
         check("t1_pre_quiet", 32'({pre_gnt_o, pre_data_en_o, pre_done_o}), 0);
         if (k == 1) drive_req(1'b0, 1'b0, '0, LEN_W'(4));
      end
      check("t1_addr_drained", 32'(addr_exp.size()), 0);
      check("t1_data_drained", 32'(vga_exp.size()), 0);

      // contention, with VGA re-requesting while PRE is still waiting
      apply_reset();
`ifdef BRAM_ARB_RR_EN
      push_burst(1'b0, ADDR_W'(20), 2);
      push_burst(1'b1, ADDR_W'(40), 2);
      push_burst(1'b0, ADDR_W'(60), 2);
      exp_pre = 6; exp_vga2 = 11;
`else
      push_burst(1'b0, ADDR_W'(20), 2);
      push_burst(1'b0, ADDR_W'(60), 2);
      push_burst(1'b1, ADDR_W'(40), 2);
      exp_vga2 = 6; exp_pre = 11;
`endif
      vga_first = -1; vga_second = -1; pre_at = -1;
      drive_req(1'b0, 1'b1, ADDR_W'(20), LEN_W'(2));
      drive_req(1'b1, 1'b1, ADDR_W'(40), LEN_W'(2));
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (vga_gnt_o) begin
            if (vga_first < 0) begin
               vga_first = k;
               vga_addr_i = ADDR_W'(60);
            end else begin
               vga_second = k;
               vga_req_i = 1'b0;
            end
         end
         if (pre_gnt_o) begin
            pre_at = k;
            pre_req_i = 1'b0;
            check("cont_pre_owner", 32'(owner_o), 1);
         end
      end
      check("cont_vga_first", 32'(vga_first), 1);
      check("cont_vga_second", 32'(vga_second), 32'(exp_vga2));
      check("cont_pre", 32'(pre_at), 32'(exp_pre));
      check("cont_addr_drained", 32'(addr_exp.size()), 0);

      // wrap at MAX_ADDR, and out-of-range base
      run_burst(1'b1, ADDR_W'(194398), 4);
      run_burst(1'b0, ADDR_W'(200000), 3);

      // zero-length bursts
      run_burst(1'b1, ADDR_W'(123), 0);
      run_burst(1'b0, ADDR_W'(5), 0);

      // reset one cycle into an 8-word PRE burst
      push_burst(1'b1, ADDR_W'(10), 8);
      drive_req(1'b1, 1'b1, ADDR_W'(10), LEN_W'(8));
      wait_gnt(1'b1, lat);
      drive_req(1'b1, 1'b0, ADDR_W'(10), LEN_W'(8));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ena", 32'(ena_o), 0);
      check("mid_rst_busy", 32'(busy_o), 0);
      check("mid_rst_owner", 32'(owner_o), 0);
      check("mid_rst_addr", 32'(addr_o), 0);
      check("mid_rst_pre_en", 32'(pre_data_en_o), 0);
      check("mid_rst_pre_done", 32'(pre_done_o), 0);
      check("mid_rst_pre_data", 32'(pre_data_o), 0);
      addr_exp.delete(); pre_exp.delete();
      rst = 1'b0;
      repeat (8) @(negedge clk);
      run_burst(1'b1, ADDR_W'(300), 3);

      // PRE request withdrawn during a VGA burst
      push_burst(1'b0, ADDR_W'(50), 8);
      drive_req(1'b0, 1'b1, ADDR_W'(50), LEN_W'(8));
      wait_gnt(1'b0, lat);
      drive_req(1'b0, 1'b0, ADDR_W'(50), LEN_W'(8));
      gcnt = pre_gnt_cnt;
      repeat (2) @(negedge clk);
      drive_req(1'b1, 1'b1, ADDR_W'(7), LEN_W'(3));
      repeat (3) @(negedge clk);
      drive_req(1'b1, 1'b0, ADDR_W'(7), LEN_W'(3));
      wait_not_busy();
      repeat (4) @(negedge clk);
      check("withdraw_no_pre_gnt", 32'(pre_gnt_cnt), 32'(gcnt));
      check("withdraw_idle", 32'(busy_o), 0);

      // a few random uncontended bursts
      for (int i = 0; i < 6; i++) begin
         run_burst(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, MAX_ADDR + 100)),
                   int'($urandom_range(1, 6)));
      end

      check("end_addr_q", 32'(addr_exp.size()), 0);
      check("end_vga_q", 32'(vga_exp.size()), 0);
      check("end_pre_q", 32'(pre_exp.size()), 0);
      check("end_zpend", 32'(vga_zpend + pre_zpend), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
